// File: rtl/radar_pulse_packer.sv
// rtl/radar_pulse_packer.sv - per-pulse capture and 12-to-16 bit packing stage for the RX FIFO
//
// Sits after the averaging decimator. Each accepted radar trigger writes a
// header word holding the pulse sequence number. The block then discards
// `delay` decimated samples and captures `length` samples. Captured samples
// are packed four 12-bit samples into three 16-bit words.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   enable       block enable; low returns the block to IDLE next cycle
//   trigger      one-cycle radar trigger
//   delay        samples discarded after the trigger (latched on acceptance)
//   length       samples captured per pulse (latched on acceptance)
//   strobe_in    decimated sample valid
//   data_in      decimated 12-bit sample
//   wr_out       one-cycle FIFO write strobe
//   data_out     16-bit FIFO word; holds its value while wr_out is low
//   busy         high whenever the state is not IDLE
//   pulse_count  accepted triggers, wraps
//   missed_count triggers ignored while busy, saturates at all-ones

module radar_pulse_packer #(
  parameter int count_width = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   trigger,
  input  logic [count_width-1:0] delay,
  input  logic [count_width-1:0] length,
  input  logic                   strobe_in,
  input  logic [11:0]            data_in,
  output logic                   wr_out,
  output logic [15:0]            data_out,
  output logic                   busy,
  output logic [count_width-1:0] pulse_count,
  output logic [count_width-1:0] missed_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    CAPTURE = 2'd2,
    FLUSH   = 2'd3
  } state_t;

  localparam logic [count_width-1:0] count_one = {{(count_width-1){1'b0}}, 1'b1};
  localparam logic [count_width-1:0] all_ones  = {count_width{1'b1}};

  state_t                 state;
  logic [count_width-1:0] delay_left;   // samples still to discard
  logic [count_width-1:0] length_left;  // samples still to capture
  logic [1:0]             slot;         // position of the next sample in its 4-sample group
  logic [11:0]            s0;
  logic [11:0]            s1;
  logic [11:0]            s2;

  // state is a register, so busy is a plain decode of registered state
  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      wr_out       <= 1'b0;
      data_out     <= 16'h0000;
      pulse_count  <= '0;
      missed_count <= '0;
      delay_left   <= '0;
      length_left  <= '0;
      slot         <= 2'd0;
      s0           <= 12'h000;
      s1           <= 12'h000;
      s2           <= 12'h000;
    end else begin
      wr_out <= 1'b0;

      // A trigger that arrives while a pulse is in progress is dropped and
      // counted; a disabled block counts nothing.
      if (trigger && enable && (state != IDLE) && (missed_count != all_ones)) begin
        missed_count <= missed_count + count_one;
      end

      if (!enable) begin
        // Abandon any partial group; the next pulse starts packing at slot 0.
        state <= IDLE;
        slot  <= 2'd0;
      end else begin
        case (state)
          IDLE: begin
            // strobe_in is deliberately ignored here, including in the
            // trigger cycle itself.
            if (trigger) begin
              delay_left  <= delay;
              length_left <= length;
              data_out    <= 16'(pulse_count);
              wr_out      <= 1'b1;
              pulse_count <= pulse_count + count_one;
              slot        <= 2'd0;
              // A zero-length pulse parks in DELAY for one cycle so that busy
              // is visible for exactly the header cycle, then returns to IDLE.
              if ((length != '0) && (delay == '0)) begin
                state <= CAPTURE;
              end else begin
                state <= DELAY;
              end
            end
          end

          DELAY: begin
            if (length_left == '0) begin
              state <= IDLE;
            end else if (strobe_in) begin
              delay_left <= delay_left - count_one;
              if (delay_left == count_one) begin
                state <= CAPTURE;
              end
            end
          end

          CAPTURE: begin
            if (strobe_in) begin
              length_left <= length_left - count_one;
              slot        <= slot + 2'd1;
              case (slot)
                2'd0: begin
                  s0 <= data_in;
                end
                2'd1: begin
                  s1       <= data_in;
                  data_out <= {s0, data_in[11:8]};
                  wr_out   <= 1'b1;
                end
                2'd2: begin
                  s2       <= data_in;
                  data_out <= {s1[7:0], data_in[11:4]};
                  wr_out   <= 1'b1;
                end
                default: begin
                  data_out <= {s2[3:0], data_in};
                  wr_out   <= 1'b1;
                end
              endcase
              // Last sample: a completed group needs no padding word.
              if (length_left == count_one) begin
                if (slot == 2'd3) begin
                  state <= IDLE;
                end else begin
                  state <= FLUSH;
                end
              end
            end
          end

          FLUSH: begin
            // slot now equals the number of leftover samples in the group.
            case (slot)
              2'd1:    data_out <= {s0, 4'h0};
              2'd2:    data_out <= {s1[7:0], 8'h00};
              2'd3:    data_out <= {s2[3:0], 12'h000};
              default: data_out <= 16'h0000;
            endcase
            wr_out <= 1'b1;
            slot   <= 2'd0;
            state  <= IDLE;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_radar_pulse_packer.sv
// tb/tb_radar_pulse_packer.sv - directed self-checking bench for radar_pulse_packer

module tb_radar_pulse_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        trigger;
  logic [15:0] delay;
  logic [15:0] length;
  logic        strobe_in;
  logic [11:0] data_in;
  logic        wr_out;
  logic [15:0] data_out;
  logic        busy;
  logic [15:0] pulse_count;
  logic [15:0] missed_count;

  logic        s_enable;
  logic        s_trigger;
  logic [3:0]  s_delay;
  logic [3:0]  s_length;
  logic        s_strobe;
  logic        s_wr;
  logic [15:0] s_data;
  logic        s_busy;
  logic [3:0]  s_pulse;
  logic [3:0]  s_missed;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int wc[$];
  logic [15:0] wd[$];

  always #5 clock = ~clock;

  radar_pulse_packer #(.count_width(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .trigger(trigger),
    .delay(delay), .length(length), .strobe_in(strobe_in), .data_in(data_in),
    .wr_out(wr_out), .data_out(data_out), .busy(busy),
    .pulse_count(pulse_count), .missed_count(missed_count)
  );

  radar_pulse_packer #(.count_width(4)) dut_small (
    .clock(clock), .reset(reset), .enable(s_enable), .trigger(s_trigger),
    .delay(s_delay), .length(s_length), .strobe_in(s_strobe), .data_in(data_in),
    .wr_out(s_wr), .data_out(s_data), .busy(s_busy),
    .pulse_count(s_pulse), .missed_count(s_missed)
  );

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (wr_out === 1'b1) begin
      wc.push_back(cyc);
      wd.push_back(data_out);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cycle_in(input logic trg, input logic stb, input logic [11:0] d);
    trigger   = trg;
    strobe_in = stb;
    data_in   = d;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; trigger = 1'b0; strobe_in = 1'b0; data_in = 12'h0;
    delay = 16'h0; length = 16'h0;
    s_enable = 1'b1; s_trigger = 1'b0; s_delay = 4'h0; s_length = 4'h0; s_strobe = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (wr_out !== 1'b0 || data_out !== 16'h0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got wr=%b data=%h busy=%b expected wr=0 data=0000 busy=0", wr_out, data_out, busy);
    end
    vectors++;
    if (pulse_count !== 16'h0 || missed_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_counts: got pulse=%h missed=%h expected 0000 0000", pulse_count, missed_count);
    end
    vectors++;
    if (s_busy !== 1'b0 || s_pulse !== 4'h0 || s_missed !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_small: got busy=%b pulse=%h missed=%h expected 0 0 0", s_busy, s_pulse, s_missed);
    end
  endtask

  task automatic test_basic();
    int t;
    int ec[4];
    logic [15:0] ed[4];
    ec[0] = 1; ed[0] = 16'h0000;
    ec[1] = 3; ed[1] = 16'h1234;
    ec[2] = 4; ed[2] = 16'h5678;
    ec[3] = 5; ed[3] = 16'h9ABC;
    wc.delete(); wd.delete();
    t = cyc; delay = 16'd0; length = 16'd4;
    cycle_in(1'b1, 1'b0, 12'h000);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_rise: got %b expected 1", busy); end
    cycle_in(1'b0, 1'b1, 12'h123);
    cycle_in(1'b0, 1'b1, 12'h456);
    cycle_in(1'b0, 1'b1, 12'h789);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_hold: got %b expected 1", busy); end
    cycle_in(1'b0, 1'b1, 12'hABC);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_fall: got %b expected 0", busy); end
    cycle_in(1'b0, 1'b0, 12'h000);
    cycle_in(1'b0, 1'b0, 12'h000);
    vectors++;
    if (wc.size() != 4) begin miscompares++; $display("FAIL basic_word_count: got %0d expected 4", wc.size()); end
    for (int i = 0; i < 4 && i < wc.size(); i++) begin
      vectors++;
      if (wc[i] != t + ec[i] || wd[i] !== ed[i]) begin
        miscompares++;
        $display("FAIL basic_word%0d: got %h at +%0d expected %h at +%0d", i, wd[i], wc[i] - t, ed[i], ec[i]);
      end
    end
    vectors++;
    if (pulse_count !== 16'd1) begin miscompares++; $display("FAIL basic_pulse_count: got %h expected 0001", pulse_count); end
  endtask

  task automatic test_delay_flush();
    int t;
    logic [11:0] d;
    int ec[3];
    logic [15:0] ed[3];
    ec[0] = 1;  ed[0] = 16'h0001;
    ec[1] = 10; ed[1] = 16'hDEF5;
    ec[2] = 11; ed[2] = 16'hA700;
    wc.delete(); wd.delete();
    t = cyc; delay = 16'd3; length = 16'd2;
    cycle_in(1'b1, 1'b1, 12'hFFF);
    for (int i = 1; i <= 10; i++) begin
      case (i)
        1: d = 12'h111;
        3: d = 12'h222;
        5: d = 12'h333;
        7: d = 12'hDEF;
        9: d = 12'h5A7;
        default: d = 12'hEEE;
      endcase
      cycle_in(1'b0, (i % 2) == 1, d);
      if (i == 9) begin
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL delay_busy_in_flush: got %b expected 1", busy); end
      end
      if (i == 10) begin
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL delay_busy_after_flush: got %b expected 0", busy); end
      end
    end
    cycle_in(1'b0, 1'b0, 12'h000);
    vectors++;
    if (wc.size() != 3) begin miscompares++; $display("FAIL delay_word_count: got %0d expected 3", wc.size()); end
    for (int i = 0; i < 3 && i < wc.size(); i++) begin
      vectors++;
      if (wc[i] != t + ec[i] || wd[i] !== ed[i]) begin
        miscompares++;
        $display("FAIL delay_word%0d: got %h at +%0d expected %h at +%0d", i, wd[i], wc[i] - t, ed[i], ec[i]);
      end
    end
  endtask

  task automatic test_length_zero_one();
    int t;
    wc.delete(); wd.delete();
    t = cyc; delay = 16'd5; length = 16'd0;
    cycle_in(1'b1, 1'b1, 12'h100);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL len0_busy_high: got %b expected 1", busy); end
    cycle_in(1'b0, 1'b1, 12'h200);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL len0_busy_low: got %b expected 0", busy); end
    cycle_in(1'b0, 1'b1, 12'h300);
    cycle_in(1'b0, 1'b0, 12'h000);
    vectors++;
    if (wc.size() != 1 || wc[0] != t + 1 || wd[0] !== 16'h0002) begin
      miscompares++;
      $display("FAIL len0_words: got %0d words first %h expected 1 word 0002 at +1", wc.size(), (wd.size() > 0) ? wd[0] : 16'hxxxx);
    end

    wc.delete(); wd.delete();
    t = cyc; delay = 16'd0; length = 16'd1;
    cycle_in(1'b1, 1'b0, 12'h000);
    cycle_in(1'b0, 1'b1, 12'hABC);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL len1_busy_flush: got %b expected 1", busy); end
    cycle_in(1'b0, 1'b1, 12'h777);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL len1_busy_low: got %b expected 0", busy); end
    cycle_in(1'b0, 1'b1, 12'h555);
    cycle_in(1'b0, 1'b0, 12'h000);
    vectors++;
    if (wc.size() != 2) begin miscompares++; $display("FAIL len1_word_count: got %0d expected 2", wc.size()); end
    else begin
      vectors++;
      if (wc[0] != t + 1 || wd[0] !== 16'h0003 || wc[1] != t + 3 || wd[1] !== 16'hABC0) begin
        miscompares++;
        $display("FAIL len1_words: got %h@+%0d %h@+%0d expected 0003@+1 ABC0@+3", wd[0], wc[0] - t, wd[1], wc[1] - t);
      end
    end
  endtask

  task automatic test_missed_retrigger();
    int t;
    int ec[5];
    logic [15:0] ed[5];
    ec[0] = 1; ed[0] = 16'h0004;
    ec[1] = 3; ed[1] = 16'h0010;
    ec[2] = 4; ed[2] = 16'h0200;
    ec[3] = 5; ed[3] = 16'h3004;
    ec[4] = 6; ed[4] = 16'h0005;
    wc.delete(); wd.delete();
    t = cyc; delay = 16'd0; length = 16'd4;
    cycle_in(1'b1, 1'b0, 12'h000);
    cycle_in(1'b0, 1'b1, 12'h001);
    cycle_in(1'b1, 1'b1, 12'h002);
    cycle_in(1'b0, 1'b1, 12'h003);
    cycle_in(1'b0, 1'b1, 12'h004);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL retrig_busy_low: got %b expected 0", busy); end
    length = 16'd0;
    cycle_in(1'b1, 1'b0, 12'h000);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL retrig_accepted: got busy %b expected 1", busy); end
    cycle_in(1'b0, 1'b0, 12'h000);
    cycle_in(1'b0, 1'b0, 12'h000);
    vectors++;
    if (wc.size() != 5) begin miscompares++; $display("FAIL retrig_word_count: got %0d expected 5", wc.size()); end
    for (int i = 0; i < 5 && i < wc.size(); i++) begin
      vectors++;
      if (wc[i] != t + ec[i] || wd[i] !== ed[i]) begin
        miscompares++;
        $display("FAIL retrig_word%0d: got %h at +%0d expected %h at +%0d", i, wd[i], wc[i] - t, ed[i], ec[i]);
      end
    end
    vectors++;
    if (missed_count !== 16'd1 || pulse_count !== 16'd6) begin
      miscompares++;
      $display("FAIL retrig_counts: got missed=%h pulse=%h expected 0001 0006", missed_count, pulse_count);
    end
  endtask

  task automatic test_enable_abort();
    int t;
    int ec[5];
    logic [15:0] ed[5];
    ec[0] = 1;  ed[0] = 16'h0006;
    ec[1] = 3;  ed[1] = 16'h0ABC;
    ec[2] = 7;  ed[2] = 16'h0007;
    ec[3] = 9;  ed[3] = 16'h3216;
    ec[4] = 10; ed[4] = 16'h5400;
    wc.delete(); wd.delete();
    t = cyc; delay = 16'd0; length = 16'd8;
    cycle_in(1'b1, 1'b0, 12'h000);
    cycle_in(1'b0, 1'b1, 12'h0AB);
    cycle_in(1'b0, 1'b1, 12'hCDE);
    enable = 1'b0;
    cycle_in(1'b0, 1'b1, 12'h111);
    vectors++;
    if (busy !== 1'b0 || wr_out !== 1'b0) begin
      miscompares++;
      $display("FAIL disable_idle: got busy=%b wr=%b expected 0 0", busy, wr_out);
    end
    cycle_in(1'b1, 1'b1, 12'h222);
    cycle_in(1'b0, 1'b0, 12'h000);
    vectors++;
    if (pulse_count !== 16'd7 || missed_count !== 16'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL disable_hold: got pulse=%h missed=%h busy=%b expected 0007 0001 0", pulse_count, missed_count, busy);
    end
    enable = 1'b1; length = 16'd2;
    cycle_in(1'b1, 1'b0, 12'h000);
    cycle_in(1'b0, 1'b1, 12'h321);
    cycle_in(1'b0, 1'b1, 12'h654);
    cycle_in(1'b0, 1'b0, 12'h000);
    cycle_in(1'b0, 1'b0, 12'h000);
    cycle_in(1'b0, 1'b0, 12'h000);
    vectors++;
    if (wc.size() != 5) begin miscompares++; $display("FAIL enable_word_count: got %0d expected 5", wc.size()); end
    for (int i = 0; i < 5 && i < wc.size(); i++) begin
      vectors++;
      if (wc[i] != t + ec[i] || wd[i] !== ed[i]) begin
        miscompares++;
        $display("FAIL enable_word%0d: got %h at +%0d expected %h at +%0d", i, wd[i], wc[i] - t, ed[i], ec[i]);
      end
    end
    vectors++;
    if (wr_out !== 1'b0 || data_out !== 16'h5400) begin
      miscompares++;
      $display("FAIL data_hold: got wr=%b data=%h expected 0 5400", wr_out, data_out);
    end
  endtask

  task automatic test_reset_abort();
    int t;
    wc.delete(); wd.delete();
    t = cyc; delay = 16'd0; length = 16'd3;
    cycle_in(1'b1, 1'b0, 12'h000);
    cycle_in(1'b0, 1'b1, 12'h123);
    reset = 1'b1;
    cycle_in(1'b0, 1'b1, 12'h456);
    reset = 1'b0;
    vectors++;
    if (busy !== 1'b0 || wr_out !== 1'b0 || data_out !== 16'h0 || pulse_count !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_abort_state: got busy=%b wr=%b data=%h pulse=%h expected 0 0 0000 0000", busy, wr_out, data_out, pulse_count);
    end
    cycle_in(1'b0, 1'b1, 12'h789);
    cycle_in(1'b0, 1'b0, 12'h000);
    cycle_in(1'b0, 1'b0, 12'h000);
    vectors++;
    if (wc.size() != 1 || wc[0] != t + 1 || wd[0] !== 16'h0008) begin
      miscompares++;
      $display("FAIL reset_abort_words: got %0d words expected only header 0008 at +1", wc.size());
    end
  endtask

  task automatic test_small_wrap();
    s_enable = 1'b1; s_delay = 4'd0; s_length = 4'd0; s_strobe = 1'b0;
    for (int k = 0; k < 16; k++) begin
      s_trigger = 1'b1;
      tick();
      if (k == 0 || k == 15) begin
        vectors++;
        if (s_wr !== 1'b1 || s_data !== 16'(k)) begin
          miscompares++;
          $display("FAIL wrap_header%0d: got wr=%b data=%h expected 1 %h", k, s_wr, s_data, 16'(k));
        end
      end
      s_trigger = 1'b0;
      tick();
    end
    vectors++;
    if (s_pulse !== 4'h0 || s_missed !== 4'h0) begin
      miscompares++;
      $display("FAIL wrap_pulse_count: got pulse=%h missed=%h expected 0 0", s_pulse, s_missed);
    end
  endtask

  task automatic test_small_saturate();
    s_delay = 4'd0; s_length = 4'd5; s_strobe = 1'b0;
    s_trigger = 1'b1;
    tick();
    for (int k = 0; k < 15; k++) tick();
    vectors++;
    if (s_missed !== 4'hF || s_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL sat_reach: got missed=%h busy=%b expected F 1", s_missed, s_busy);
    end
    for (int k = 0; k < 5; k++) tick();
    s_trigger = 1'b0;
    vectors++;
    if (s_missed !== 4'hF || s_pulse !== 4'h1) begin
      miscompares++;
      $display("FAIL sat_hold: got missed=%h pulse=%h expected F 1", s_missed, s_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay_flush();
    test_length_zero_one();
    test_missed_retrigger();
    test_enable_abort();
    test_reset_abort();
    test_small_wrap();
    test_small_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
